// File: rtl/csr_exec_ctrl_if.sv
// Bundle of the decode, CSRU and writeback signals of csr_exec_ctrl.
// The master side (decode, CSRU model, writeback) drives the slave (sequencer).
interface csr_exec_ctrl_if #(
  parameter int XLEN = 32
);
  // valid/ready: a transfer happens on a rising clk edge where both valid and
  // ready are high; the producer holds valid and payload until that edge.
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            is_ecall;
  logic            is_mret;
  logic [11:0]     csr_idx;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] pc_in;

  logic            csr_wen;
  logic [2:0]      csr_ctl;
  logic [XLEN-1:0] csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_pc;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] csr_upc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;

  modport master (
    output in_valid, funct3, is_ecall, is_mret, csr_idx, rs1_idx, rs1_val, pc_in,
    output csr_rdata, csr_upc, out_ready,
    input  in_ready, csr_wen, csr_ctl, csr_addr, csr_wdata, csr_pc,
    input  out_valid, rd_data, redirect, redirect_pc, illegal
  );

  modport slave (
    input  in_valid, funct3, is_ecall, is_mret, csr_idx, rs1_idx, rs1_val, pc_in,
    input  csr_rdata, csr_upc, out_ready,
    output in_ready, csr_wen, csr_ctl, csr_addr, csr_wdata, csr_pc,
    output out_valid, rd_data, redirect, redirect_pc, illegal
  );
endinterface

// File: rtl/csr_exec_ctrl.sv
// Sequencer that runs one SYSTEM instruction (CSR ops, ECALL, MRET) against the CSRU.
// Optional CSR_ILLEGAL_EN: unknown CSR addresses complete as illegal without touching the CSRU.
`ifndef CSRW
`define CSRW 3'd1
`endif
`ifndef ECALL
`define ECALL 3'd2
`endif
`ifndef MRET
`define MRET 3'd3
`endif

module csr_exec_ctrl #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  csr_exec_ctrl_if.slave   bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_TRAP = 3'd3,
    S_RET  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [CSR_ADDR_W-1:0] csr_idx_q, csr_idx_d;
  logic [4:0]            rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]       rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       old_q, old_d;
  logic                  redirect_q, redirect_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  illegal_q, illegal_d;

  logic                  accept;
  logic                  need_wr;
  logic [XLEN-1:0]       src;
  logic [XLEN-1:0]       new_val;
  logic [XLEN-1:0]       addr_ext;

`ifdef CSR_ILLEGAL_EN
  function automatic logic csr_known(input logic [CSR_ADDR_W-1:0] idx);
    return (idx == CSR_ADDR_W'(12'h300)) || (idx == CSR_ADDR_W'(12'h305)) ||
           (idx == CSR_ADDR_W'(12'h341)) || (idx == CSR_ADDR_W'(12'h342));
  endfunction
`endif

  assign accept    = bus.in_valid && (state_q == S_IDLE);
  assign dbg_state = state_q;
  assign addr_ext  = {{(XLEN-CSR_ADDR_W){1'b0}}, csr_idx_q};

  // funct3[2] selects the uimm variants; rs1_idx==0 suppresses S/C writes.
  assign src     = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
  assign need_wr = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

  always_comb begin
    case (funct3_q[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_q | src;
      default: new_val = old_q & ~src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      funct3_q      <= '0;
      csr_idx_q     <= '0;
      rs1_idx_q     <= '0;
      rs1_val_q     <= '0;
      pc_q          <= '0;
      old_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      csr_idx_q     <= csr_idx_d;
      rs1_idx_q     <= rs1_idx_d;
      rs1_val_q     <= rs1_val_d;
      pc_q          <= pc_d;
      old_q         <= old_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    csr_idx_d     = csr_idx_q;
    rs1_idx_d     = rs1_idx_q;
    rs1_val_d     = rs1_val_q;
    pc_d          = pc_q;
    old_d         = old_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d      = bus.funct3;
          csr_idx_d     = bus.csr_idx[CSR_ADDR_W-1:0];
          rs1_idx_d     = bus.rs1_idx;
          rs1_val_d     = bus.rs1_val;
          pc_d          = bus.pc_in;
          old_d         = '0;
          redirect_d    = 1'b0;
          redirect_pc_d = '0;
          illegal_d     = 1'b0;
          if (bus.is_ecall)                  state_d = S_TRAP;
          else if (bus.is_mret)              state_d = S_RET;
          else if (bus.funct3[1:0] != 2'b00) begin
`ifdef CSR_ILLEGAL_EN
            if (csr_known(bus.csr_idx[CSR_ADDR_W-1:0])) state_d = S_RD;
            else begin
              illegal_d = 1'b1;
              state_d   = S_DONE;
            end
`else
            state_d = S_RD;
`endif
          end else                           state_d = S_DONE;
        end
      end
      S_RD: begin
        old_d   = bus.csr_rdata;
        state_d = need_wr ? S_WR : S_DONE;
      end
      S_WR:   state_d = S_DONE;
      S_TRAP, S_RET: begin
        redirect_d    = 1'b1;
        redirect_pc_d = bus.csr_upc;
        state_d       = S_DONE;
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CSRU-side outputs are decoded from the state alone so they are 0 outside RD/WR/TRAP/RET.
  always_comb begin
    bus.in_ready    = (state_q == S_IDLE);
    bus.out_valid   = (state_q == S_DONE);
    bus.csr_wen     = 1'b0;
    bus.csr_ctl     = 3'd0;
    bus.csr_addr    = '0;
    bus.csr_wdata   = '0;
    bus.csr_pc      = '0;
    bus.rd_data     = old_q;
    bus.redirect    = redirect_q;
    bus.redirect_pc = redirect_pc_q;
    bus.illegal     = illegal_q;
    case (state_q)
      S_RD: bus.csr_addr = addr_ext;
      S_WR: begin
        bus.csr_wen   = 1'b1;
        bus.csr_ctl   = `CSRW;
        bus.csr_addr  = addr_ext;
        bus.csr_wdata = new_val;
      end
      S_TRAP: begin
        bus.csr_wen = 1'b1;
        bus.csr_ctl = `ECALL;
        bus.csr_pc  = pc_q;
      end
      S_RET:   bus.csr_ctl = `MRET;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_ctrl.sv
// Randomized bench for csr_exec_ctrl with a behavioural CSR-file reference model.
// Directed cases cover the documented examples, DONE back-pressure and reset mid-operation.
module tb_csr_exec_ctrl;
  localparam int XLEN = 32;
  localparam logic [2:0] C_CSRW  = 3'd1;
  localparam logic [2:0] C_ECALL = 3'd2;
  localparam logic [2:0] C_MRET  = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  csr_exec_ctrl_if #(.XLEN(XLEN)) bus ();

  csr_exec_ctrl #(.XLEN(XLEN), .CSR_ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // CSR address map shared by the CSRU model and the reference model
  logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h341, 12'h342,
                                12'h340, 12'h7c0, 12'hf14, 12'h001};
  localparam int I_MTVEC = 1, I_MEPC = 2, I_MCAUSE = 3;
  logic [31:0] csru_mem [8];
  logic [31:0] ref_mem  [8];

  function automatic int slot_of(input logic [31:0] a);
    for (int i = 0; i < 8; i++) if (a == {20'h0, addr_tab[i]}) return i;
    return -1;
  endfunction

  // CSRU model: combinational reads, writes on the clock edge
  always_comb begin
    bus.csr_rdata = 32'h0;
    for (int i = 0; i < 8; i++)
      if (bus.csr_addr == {20'h0, addr_tab[i]}) bus.csr_rdata = csru_mem[i];
    if (bus.csr_ctl == C_ECALL)     bus.csr_upc = csru_mem[I_MTVEC];
    else if (bus.csr_ctl == C_MRET) bus.csr_upc = csru_mem[I_MEPC];
    else                            bus.csr_upc = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.csr_wen) begin
      if (bus.csr_ctl == C_CSRW && slot_of(bus.csr_addr) >= 0)
        csru_mem[slot_of(bus.csr_addr)] <= bus.csr_wdata;
      else if (bus.csr_ctl == C_ECALL) begin
        csru_mem[I_MEPC]   <= bus.csr_pc;
        csru_mem[I_MCAUSE] <= 32'd11;
      end
    end
  end

  function automatic bit known_csr(input logic [11:0] idx);
`ifdef CSR_ILLEGAL_EN
    return idx == 12'h300 || idx == 12'h305 || idx == 12'h341 || idx == 12'h342;
`else
    return (idx == idx);
`endif
  endfunction

  task automatic check_mems(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_csr%03h", tag, addr_tab[i]), csru_mem[i], ref_mem[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"},   32'(bus.out_valid), 32'd0);
    check({tag, "_csr_wen"},     32'(bus.csr_wen),   32'd0);
    check({tag, "_csr_ctl"},     32'(bus.csr_ctl),   32'd0);
    check({tag, "_csr_addr"},    bus.csr_addr,       32'd0);
    check({tag, "_csr_wdata"},   bus.csr_wdata,      32'd0);
    check({tag, "_csr_pc"},      bus.csr_pc,         32'd0);
    check({tag, "_rd_data"},     bus.rd_data,        32'd0);
    check({tag, "_redirect"},    32'(bus.redirect),  32'd0);
    check({tag, "_redirect_pc"}, bus.redirect_pc,    32'd0);
    check({tag, "_illegal"},     32'(bus.illegal),   32'd0);
  endtask

  task automatic scramble_inputs();
    bus.funct3   = 3'($urandom_range(0, 7));
    bus.is_ecall = 1'($urandom_range(0, 1));
    bus.is_mret  = 1'($urandom_range(0, 1));
    bus.csr_idx  = 12'($urandom);
    bus.rs1_idx  = 5'($urandom);
    bus.rs1_val  = $urandom;
    bus.pc_in    = $urandom;
  endtask

  // Driver + expectation for one instruction; called at a negedge with the DUT idle.
  task automatic run_instr(input string tag, input logic [2:0] f3, input bit ec, input bit mr,
                           input int si, input logic [4:0] r1i, input logic [31:0] r1v,
                           input logic [31:0] pc, input int hold);
    logic [11:0] idx;
    logic [31:0] old, srcv, newv;
    int          lat, wen_k;
    logic [31:0] e_rd, e_rpc, e_addr, e_wdata, e_pc;
    logic [2:0]  e_ctl;
    bit          e_redir, e_ill, wr;
    int          waited;

    idx = addr_tab[si];
    lat = 1; wen_k = 0; e_rd = 0; e_rpc = 0; e_redir = 0; e_ill = 0;
    e_addr = 0; e_wdata = 0; e_pc = 0; e_ctl = 0;
    if (ec) begin
      lat = 2; wen_k = 1; e_redir = 1; e_rpc = ref_mem[I_MTVEC];
      e_ctl = C_ECALL; e_pc = pc;
      ref_mem[I_MEPC] = pc; ref_mem[I_MCAUSE] = 32'd11;
    end else if (mr) begin
      lat = 2; e_redir = 1; e_rpc = ref_mem[I_MEPC];
    end else if (f3 != 3'b000 && f3 != 3'b100) begin
      if (!known_csr(idx)) begin
        e_ill = 1;
      end else begin
        old  = ref_mem[si];
        srcv = f3[2] ? {27'h0, r1i} : r1v;
        wr   = (f3 == 3'b001 || f3 == 3'b101) || (r1i != 0);
        if (f3 == 3'b001 || f3 == 3'b101)      newv = srcv;
        else if (f3 == 3'b010 || f3 == 3'b110) newv = old | srcv;
        else                                   newv = old & ~srcv;
        e_rd = old;
        if (wr) begin
          lat = 3; wen_k = 2; e_ctl = C_CSRW; e_addr = {20'h0, idx}; e_wdata = newv;
          ref_mem[si] = newv;
        end else lat = 2;
      end
    end

    waited = 0;
    while (!bus.in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1; bus.funct3 = f3; bus.is_ecall = ec; bus.is_mret = mr;
    bus.csr_idx = idx; bus.rs1_idx = r1i; bus.rs1_val = r1v; bus.pc_in = pc;

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      scramble_inputs();
      bus.in_valid = 1'($urandom_range(0, 1));
      check($sformatf("%s_out_valid_t%0d", tag, k), 32'(bus.out_valid), 32'(k == lat));
      check($sformatf("%s_in_ready_t%0d", tag, k), 32'(bus.in_ready), 32'd0);
      check($sformatf("%s_csr_wen_t%0d", tag, k), 32'(bus.csr_wen), 32'(k == wen_k));
      if (k == wen_k) begin
        check({tag, "_csr_ctl"},   32'(bus.csr_ctl), 32'(e_ctl));
        check({tag, "_csr_addr"},  bus.csr_addr,     e_addr);
        check({tag, "_csr_wdata"}, bus.csr_wdata,    e_wdata);
        check({tag, "_csr_pc"},    bus.csr_pc,       e_pc);
      end
    end

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        scramble_inputs();
        bus.in_valid = 1'($urandom_range(0, 1));
        check({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_hold_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_hold_csr_wen"},   32'(bus.csr_wen),   32'd0);
      end
      check({tag, "_rd_data"},     bus.rd_data,       e_rd);
      check({tag, "_redirect"},    32'(bus.redirect), 32'(e_redir));
      check({tag, "_redirect_pc"}, bus.redirect_pc,   e_rpc);
      check({tag, "_illegal"},     32'(bus.illegal),  32'(e_ill));
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_in_ready"},  32'(bus.in_ready),  32'd1);
    check_mems(tag);
  endtask

  task automatic run_reset_in_rd();
    bus.in_valid = 1'b1; bus.funct3 = 3'b001; bus.is_ecall = 1'b0; bus.is_mret = 1'b0;
    bus.csr_idx = addr_tab[0]; bus.rs1_idx = 5'd7; bus.rs1_val = 32'hDEAD_BEEF; bus.pc_in = 32'h100;
    @(negedge clk);
    check("rstmid_in_rd_addr", bus.csr_addr, {20'h0, addr_tab[0]});
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rstmid");
    @(negedge clk);
    check("rstmid_no_wen", 32'(bus.csr_wen), 32'd0);
    check_mems("rstmid");
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.funct3 = 3'd0; bus.is_ecall = 1'b0; bus.is_mret = 1'b0;
    bus.csr_idx = 12'd0; bus.rs1_idx = 5'd0; bus.rs1_val = 32'd0; bus.pc_in = 32'd0;
    for (int i = 0; i < 8; i++) begin
      csru_mem[i] = $urandom;
      ref_mem[i]  = csru_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    run_instr("csrrw_mtvec",  3'b001, 0, 0, I_MTVEC,  5'd5, 32'h8000_0100, 32'h0, 0);
    run_instr("csrrs_nowr",   3'b010, 0, 0, I_MCAUSE, 5'd0, 32'hFFFF_FFFF, 32'h0, 0);
    run_instr("csrrw_mepc",   3'b001, 0, 0, I_MEPC,   5'd3, 32'h0000_001F, 32'h0, 0);
    run_instr("csrrci_mepc",  3'b111, 0, 0, I_MEPC,   5'd3, 32'h0,         32'h0, 0);
    check("csrrci_result", csru_mem[I_MEPC], 32'h0000_001C);
    run_instr("ecall",        3'b000, 1, 0, 0,        5'd0, 32'h0, 32'h8000_0010, 0);
    run_instr("mret",         3'b000, 0, 1, 0,        5'd0, 32'h0, 32'h0, 0);
    run_instr("hold3",        3'b110, 0, 0, 4,        5'd9, 32'h0, 32'h0, 3);
    run_instr("noop",         3'b100, 0, 0, 0,        5'd1, 32'h1, 32'h0, 1);
    run_reset_in_rd();

    for (int n = 0; n < 250; n++) begin
      int r;
      logic [4:0] r1i;
      r   = $urandom_range(0, 15);
      r1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_instr($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), r == 0, r == 1,
                $urandom_range(0, 7), r1i, $urandom, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
